bmux_16: RTL and testbench

//   16-way, WIDTH-bit bus multiplexer for the processor datapath (register-file

---
 rtl/bmux_16.sv | 61 ++++++
 tb/tb_bmux_16.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bmux_16.sv
// 16-way WIDTH-bit bus multiplexer with a registered copy of the selected word.
// r is purely combinational; r_q captures r on enabled rising edges.
module bmux_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] O,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q
);

  // All 16 codes are decoded, so the leading default only keeps the block latch-free.
  always_comb begin
    r = A;
    case (s)
      4'd0:  r = A;
      4'd1:  r = B;
      4'd2:  r = C;
      4'd3:  r = D;
      4'd4:  r = E;
      4'd5:  r = F;
      4'd6:  r = G;
      4'd7:  r = H;
      4'd8:  r = I;
      4'd9:  r = J;
      4'd10: r = K;
      4'd11: r = L;
      4'd12: r = M;
      4'd13: r = N;
      4'd14: r = O;
      4'd15: r = P;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r;
    end
  end

endmodule

// File: tb/tb_bmux_16.sv
// Self-checking bench for bmux_16: directed cases plus randomized traffic
// compared against an array-indexed reference model.
module tb_bmux_16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  s;
  logic [15:0] din [16];
  logic [15:0] r;
  logic [15:0] r_q;
  logic [15:0] exp_q;
  int          n_cmp;
  int          n_err;

  bmux_16 #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .s    (s),
    .A    (din[0]),
    .B    (din[1]),
    .C    (din[2]),
    .D    (din[3]),
    .E    (din[4]),
    .F    (din[5]),
    .G    (din[6]),
    .H    (din[7]),
    .I    (din[8]),
    .J    (din[9]),
    .K    (din[10]),
    .L    (din[11]),
    .M    (din[12]),
    .N    (din[13]),
    .O    (din[14]),
    .P    (din[15]),
    .r    (r),
    .r_q  (r_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the selected word is simply the s-th entry of the input array.
  function automatic logic [15:0] ref_sel(input logic [3:0] sel);
    return din[sel];
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    en    = 1'b0;
    s     = 4'd0;
    for (int k = 0; k < 16; k++) din[k] = 16'h0000;
    exp_q = 16'h0000;

    #1;
    check("reset_rq", r_q, 16'h0000);

    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      #1;
      check("zero_sweep", r, 16'h0000);
    end

    for (int k = 0; k < 16; k++) din[k] = 16'(k + 1);
    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      #1;
      check("inc_sweep", r, 16'(k + 1));
    end

    s = 4'd7;
    #1;
    check("sel7", r, 16'd8);
    din[0] = 16'hFFFF;
    #1;
    check("nonsel_change", r, 16'd8);
    din[7] = 16'h1234;
    #1;
    check("sel_change", r, 16'h1234);

    for (int k = 0; k < 16; k++) din[k] = 16'h0001 << k;
    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      #1;
      check("walk1", r, 16'h0001 << k);
    end
    for (int k = 0; k < 16; k++) din[k] = ~(16'h0001 << k);
    for (int k = 0; k < 16; k++) begin
      s = 4'(k);
      #1;
      check("walk0", r, ~(16'h0001 << k));
    end
    check("rq_held_in_reset", r_q, 16'h0000);

    // Reset release, load D, then hold with en low.
    @(negedge clk);
    for (int k = 0; k < 16; k++) din[k] = 16'(k + 1);
    rst_n = 1'b1;
    en    = 1'b1;
    s     = 4'd3;
    @(posedge clk);
    #1;
    check("load_d", r_q, 16'd4);
    @(negedge clk);
    en = 1'b0;
    s  = 4'd5;
    @(posedge clk);
    #1;
    check("hold_en0", r_q, 16'd4);

    // Asynchronous reset between edges with en high.
    @(negedge clk);
    en    = 1'b1;
    s     = 4'd9;
    rst_n = 1'b0;
    #1;
    check("midcycle_rst_rq", r_q, 16'h0000);
    check("midcycle_rst_r", r, 16'd10);
    s = 4'd12;
    #1;
    check("rst_r_follows", r, 16'd13);
    rst_n = 1'b1;
    exp_q = 16'h0000;

    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) din[k] = 16'($urandom);
      s  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_r", r, ref_sel(s));
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst", r_q, 16'h0000);
        exp_q = 16'h0000;
        rst_n = 1'b1;
      end
      @(posedge clk);
      if (en) exp_q = ref_sel(s);
      #1;
      check("rnd_rq", r_q, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
